// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux scan controller: FSM states and channel/data widths.
package mux_scan_pkg;
    localparam int NCH    = 4;
    localparam int SEL_W  = 2;
    localparam int DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Upstream word / downstream result handshake bundle for mux_scan_ctrl.
interface mux_scan_ctrl_if;
    import mux_scan_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_err;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/mux_scan_step_cnt.sv
// Hold counter for each select value; last pulses on the final cycle of a hold.
module mux_scan_step_cnt #(
    parameter int HOLD_CYC = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic last
);
    localparam logic [3:0] LAST_VAL = 4'(HOLD_CYC - 1);

    logic [3:0] cnt_reg;

    assign last = en && (cnt_reg == LAST_VAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= 4'd0;
        end else if (clr || last) begin
            cnt_reg <= 4'd0;
        end else if (en) begin
            cnt_reg <= cnt_reg + 4'd1;
        end
    end
endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans an accepted word through an external 4:1 mux and reassembles/compares the returned bits.
// Optional saturating mismatch counter on port err_cnt when MUX_SCAN_ERR_CNT_EN is defined.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int HOLD_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    mux_scan_ctrl_if.slave    bus,
    output logic [DATA_W-1:0] mux_a,
    output logic [SEL_W-1:0]  mux_s,
    input  logic              mux_y
`ifdef MUX_SCAN_ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);
    state_t            state_reg, state_next;
    logic [DATA_W-1:0] mux_a_reg, mux_a_next;
    logic [SEL_W-1:0]  mux_s_reg, mux_s_next;
    logic [DATA_W-1:0] out_data_reg, out_data_next;
    logic              out_err_reg, out_err_next;
    logic              cap_done_reg, cap_done_next;
    logic              accept;
    logic              capture;
    logic              step_last;

    mux_scan_step_cnt #(
        .HOLD_CYC (HOLD_CYC)
    ) u_step_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    ((state_reg == SCAN) && !cap_done_reg),
        .last  (step_last)
    );

    // Bit k of the result only loads while select k is being sampled.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_cap
            assign out_data_next[gi] = (capture && (mux_s_reg == SEL_W'(gi))) ? mux_y
                                                                              : out_data_reg[gi];
        end
    endgenerate

    // cap_done marks the extra cycle after the last sample, used to compare the full word.
    always_comb begin
        state_next    = state_reg;
        mux_a_next    = mux_a_reg;
        mux_s_next    = mux_s_reg;
        out_err_next  = out_err_reg;
        cap_done_next = cap_done_reg;
        accept        = 1'b0;
        capture       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    accept        = 1'b1;
                    state_next    = SCAN;
                    mux_a_next    = bus.in_data;
                    mux_s_next    = '0;
                    cap_done_next = 1'b0;
                end
            end
            SCAN: begin
                if (cap_done_reg) begin
                    state_next    = DONE;
                    cap_done_next = 1'b0;
                    out_err_next  = (out_data_reg != mux_a_reg);
                end else if (step_last) begin
                    capture = 1'b1;
                    if (mux_s_reg == SEL_W'(NCH - 1)) begin
                        cap_done_next = 1'b1;
                    end else begin
                        mux_s_next = mux_s_reg + SEL_W'(1);
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next   = IDLE;
                    out_err_next = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mux_a_reg    <= '0;
            mux_s_reg    <= '0;
            out_data_reg <= '0;
            out_err_reg  <= 1'b0;
            cap_done_reg <= 1'b0;
        end else begin
            mux_a_reg    <= mux_a_next;
            mux_s_reg    <= mux_s_next;
            out_data_reg <= out_data_next;
            out_err_reg  <= out_err_next;
            cap_done_reg <= cap_done_next;
        end
    end

`ifdef MUX_SCAN_ERR_CNT_EN
    logic [7:0] err_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_reg <= 8'd0;
        end else if ((state_reg == SCAN) && cap_done_reg && (out_data_reg != mux_a_reg)
                     && (err_cnt_reg != 8'hFF)) begin
            err_cnt_reg <= err_cnt_reg + 8'd1;
        end
    end

    assign err_cnt = err_cnt_reg;
`endif

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.out_data  = out_data_reg;
    assign bus.out_err   = out_err_reg;
    assign mux_a         = mux_a_reg;
    assign mux_s         = mux_s_reg;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: random words with injected mux faults, stall, reset abort, saturation.
`timescale 1ns/1ps
module tb_mux_scan_ctrl;
    import mux_scan_pkg::*;

    localparam int P  = 10;
    localparam int H  = 1;
    localparam int H3 = 3;

    logic clk = 1'b0;
    always #(P/2) clk = ~clk;

    logic       rst_n, rst3_n;
    logic [3:0] mux_a, mux_a3;
    logic [1:0] mux_s, mux_s3;
    logic       mux_y, mux_y3;
    logic [3:0] cur_mask;
    logic       force_zero;
    logic       rnd_ready;
    logic       done3;

    mux_scan_ctrl_if bus();
    mux_scan_ctrl_if bus3();

`ifdef MUX_SCAN_ERR_CNT_EN
    logic [7:0] err_cnt, err_cnt3;
`endif

    // Downstream mux model; the mask corrupts returned bits to provoke mismatches.
    assign mux_y  = force_zero ? 1'b0 : (mux_a[mux_s] ^ cur_mask[mux_s]);
    assign mux_y3 = mux_a3[mux_s3];

    mux_scan_ctrl #(.HOLD_CYC(H)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .mux_a   (mux_a),
        .mux_s   (mux_s),
        .mux_y   (mux_y)
`ifdef MUX_SCAN_ERR_CNT_EN
        ,
        .err_cnt (err_cnt)
`endif
    );

    mux_scan_ctrl #(.HOLD_CYC(H3)) dut3 (
        .clk     (clk),
        .rst_n   (rst3_n),
        .bus     (bus3.slave),
        .mux_a   (mux_a3),
        .mux_s   (mux_s3),
        .mux_y   (mux_y3)
`ifdef MUX_SCAN_ERR_CNT_EN
        ,
        .err_cnt (err_cnt3)
`endif
    );

    int checks   = 0;
    int failures = 0;
    int model_cnt = 0;

    typedef struct {
        logic [3:0] word;
        logic [3:0] data;
        logic       err;
        time        t_acc;
    } exp_t;
    exp_t sbq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [3:0] w, input logic [3:0] m);
        int   n;
        exp_t e;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("accept_wait", bus.in_ready, 1);
        if (bus.in_ready) begin
            bus.in_data  = w;
            bus.in_valid = 1'b1;
            cur_mask     = m;
            @(posedge clk);
            e.word  = w;
            e.data  = force_zero ? 4'b0000 : (w ^ m);
            e.err   = (e.data != w);
            e.t_acc = $time;
            sbq.push_back(e);
            #1;
            bus.in_valid = 1'b0;
            bus.in_data  = 4'($urandom);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || !bus.in_ready) && n < 300) begin
            @(posedge clk); #1; n++;
        end
        chk("drain", sbq.size(), 0);
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectation.
    bit prev_ov = 1'b0;
    int k, es;
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n) begin
            chk("err_outside_done", bus.out_err & ~bus.out_valid, 0);
            if (sbq.size() == 0) begin
                if (bus.out_valid) chk("unexpected_valid", bus.out_valid, 0);
            end else begin
                k = int'(($time - sbq[0].t_acc - P/2) / P);
                if (!bus.out_valid) begin
                    es = (k / H > 3) ? 3 : k / H;
                    chk("in_ready_busy", bus.in_ready, 0);
                    chk("mux_s_seq", mux_s, es);
                    chk("mux_a_scan", mux_a, sbq[0].word);
                end else begin
                    if (!prev_ov) begin
                        chk("latency", k, 4 * H + 1);
                        chk("sel_at_done", mux_s, 3);
                    end
                    if (bus.out_ready) begin
                        mon_e = sbq.pop_front();
                        chk("out_data", bus.out_data, mon_e.data);
                        chk("out_err", bus.out_err, mon_e.err);
                        if (mon_e.err && model_cnt < 255) model_cnt++;
`ifdef MUX_SCAN_ERR_CNT_EN
                        chk("err_cnt", err_cnt, model_cnt);
`endif
                    end
                end
            end
            prev_ov = bus.out_valid;
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #(P * 60000);
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // HOLD_CYC=3 instance: directed hold/latency check.
    initial begin
        logic [3:0] w3;
        done3          = 1'b0;
        rst3_n         = 1'b0;
        bus3.in_valid  = 1'b0;
        bus3.in_data   = 4'd0;
        bus3.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst3_n = 1'b1;
        chk("h3_ready_after_reset", bus3.in_ready, 1);
        for (int t = 0; t < 3; t++) begin
            w3 = (t == 0) ? 4'b0110 : 4'($urandom);
            bus3.in_data  = w3;
            bus3.in_valid = 1'b1;
            @(posedge clk); #1;
            bus3.in_valid = 1'b0;
            for (int kk = 0; kk <= 13; kk++) begin
                @(negedge clk);
                if (kk < 13) begin
                    chk("h3_mux_s_hold", mux_s3, (kk / 3 > 3) ? 3 : kk / 3);
                    chk("h3_no_valid", bus3.out_valid, 0);
                end else begin
                    chk("h3_latency_valid", bus3.out_valid, 1);
                    chk("h3_out_data", bus3.out_data, w3);
                    chk("h3_out_err", bus3.out_err, 0);
                end
            end
            @(posedge clk); #1;
            chk("h3_valid_drop", bus3.out_valid, 0);
        end
        done3 = 1'b1;
    end

    initial begin
        logic [3:0] w, m, ed;
        int n;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 4'd0;
        bus.out_ready = 1'b0;
        cur_mask      = 4'd0;
        force_zero    = 1'b0;
        rnd_ready     = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_mux_a", mux_a, 0);
        chk("rst_mux_s", mux_s, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("ready_after_reset", bus.in_ready, 1);
        bus.out_ready = 1'b1;

        send(4'b1010, 4'b0000);
        drain();

        rnd_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            w = 4'($urandom);
            m = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(1, 15));
            send(w, m);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        drain();

        // Stall in DONE with in_valid noise.
        rnd_ready     = 1'b0;
        bus.out_ready = 1'b0;
        w  = 4'($urandom);
        m  = 4'($urandom);
        ed = w ^ m;
        send(w, m);
        n = 0;
        while (!bus.out_valid && n < 100) begin @(posedge clk); #1; n++; end
        chk("stall_valid", bus.out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            bus.in_data  = ~w;
            @(negedge clk);
            chk("stall_out_data", bus.out_data, ed);
            chk("stall_out_err", bus.out_err, (ed != w));
            chk("stall_mux_a", mux_a, w);
            chk("stall_mux_s", mux_s, 3);
            chk("stall_in_ready", bus.in_ready, 0);
            chk("stall_out_valid", bus.out_valid, 1);
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("drop_after_ready", bus.out_valid, 0);
        chk("idle_after_ready", bus.in_ready, 1);
        rnd_ready = 1'b1;
        drain();

        // Asynchronous reset in the middle of a scan.
        send(4'b1011, 4'b0000);
        n = 0;
        while (mux_s != 2'd2 && n < 50) begin @(posedge clk); #1; n++; end
        chk("reach_sel2", mux_s, 2);
        #2;
        rst_n = 1'b0;
        sbq.delete();
        model_cnt = 0;
        #1;
        chk("arst_in_ready", bus.in_ready, 1);
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_out_data", bus.out_data, 0);
        chk("arst_out_err", bus.out_err, 0);
        chk("arst_mux_a", mux_a, 0);
        chk("arst_mux_s", mux_s, 0);
`ifdef MUX_SCAN_ERR_CNT_EN
        chk("arst_err_cnt", err_cnt, 0);
`endif
        #1;
        rst_n = 1'b1;
        chk("arst_ready_release", bus.in_ready, 1);
        @(posedge clk); #1;
        send(4'b0001, 4'b0000);
        drain();

        // Stuck-at-zero mux output; counter must saturate.
        force_zero = 1'b1;
        send(4'b1111, 4'b0000);
        drain();
`ifdef MUX_SCAN_ERR_CNT_EN
        chk("err_cnt_first", err_cnt, 1);
`endif
        for (int i = 0; i < 299; i++) send(4'b1111, 4'b0000);
        drain();
`ifdef MUX_SCAN_ERR_CNT_EN
        chk("err_cnt_sat", err_cnt, 255);
`endif
        force_zero = 1'b0;

        n = 0;
        while (!done3 && n < 1000) begin @(posedge clk); n++; end
        chk("h3_done", done3, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
